// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage between fetch and execute.
// Latency: 1 cycle from in_valid&in_ready to out_valid.
// Backpressure: outputs held while out_valid&!out_ready; in_ready also drops on a load-scoreboard hazard.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         fetch handshake; in_instr/in_pc carried with it
//   flush                     kill the registered instruction (and any same-cycle accept)
//   out_valid/out_ready       execute handshake; out_pc plus decoded controls
//   alu_ctrl, imm, sel_a/b    ALU function, sign-extended immediate, operand selects
//   sel_out, imm_en           destination register (0 = none), operand B = immediate
//   jmp_type, new_jmp         control-transfer kind and strobe
//   lam_control, lam_new      load/store unit command and strobe; demux_alu routes ALU to it
//   illegal                   instruction could not be decoded
//   wb_valid, wb_rd           load writeback, releases the scoreboard bit for wb_rd
module decode_stage #(
  parameter int XLEN          = 32,
  parameter bit EN_MULDIV     = 1'b0,
  parameter bit EN_SCOREBOARD = 1'b1,
  parameter int PC_SEL        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [9:0]      alu_ctrl,
  output logic [XLEN-1:0] imm,
  output logic [5:0]      sel_a,
  output logic [4:0]      sel_b,
  output logic [5:0]      sel_out,
  output logic            imm_en,
  output logic [2:0]      jmp_type,
  output logic            new_jmp,
  output logic [8:0]      lam_control,
  output logic            lam_new,
  output logic            demux_alu,
  output logic            illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [9:0]      alu_ctrl;
    logic [XLEN-1:0] imm;
    logic [5:0]      sel_a;
    logic [4:0]      sel_b;
    logic [5:0]      sel_out;
    logic            imm_en;
    logic [2:0]      jmp_type;
    logic            new_jmp;
    logic [8:0]      lam_control;
    logic            lam_new;
    logic            demux_alu;
    logic            illegal;
  } dec_t;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign f7  = in_instr[31:25];

  dec_t            dec_d, dec_q;
  logic            out_valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     sb_d, sb_q;
  logic [31:0]     imm32;
  logic            uses_rs1, uses_rs2, writes_rd, is_load;
  logic            hazard, in_fire;

  always_comb begin
    dec_d     = '0;
    imm32     = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_d.illegal = 1'b1;
    end else begin
      unique case (opc)
        OPC_R: begin
          if (f7 == 7'b0000000 || f7 == 7'b0100000 || (EN_MULDIV && f7 == 7'b0000001)) begin
            dec_d.sel_a    = {1'b0, rs1};
            dec_d.sel_b    = rs2;
            dec_d.sel_out  = {1'b0, rd};
            dec_d.alu_ctrl = {f7, f3};
            {uses_rs1, uses_rs2, writes_rd} = 3'b111;
          end else begin
            dec_d.illegal = 1'b1;
          end
        end
        OPC_IMM: begin
          imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_d.sel_a    = {1'b0, rs1};
          dec_d.sel_out  = {1'b0, rd};
          dec_d.imm_en   = 1'b1;
          // Only the shifts carry a meaningful funct7 (SRAI vs SRLI); for the rest
          // those bits are immediate data and must not leak into the ALU function.
          dec_d.alu_ctrl = (f3 == 3'b001 || f3 == 3'b101) ? {f7, f3} : {7'b0, f3};
          {uses_rs1, writes_rd} = 2'b11;
        end
        OPC_LUI, OPC_AUIPC: begin
          imm32         = {in_instr[31:12], 12'b0};
          dec_d.sel_a   = (opc == OPC_AUIPC) ? 6'(PC_SEL) : 6'd0;
          dec_d.sel_out = {1'b0, rd};
          dec_d.imm_en  = 1'b1;
          writes_rd     = 1'b1;
        end
        OPC_LOAD: begin
          // The load result returns through the LAM unit, so no ALU writeback here.
          imm32             = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_d.sel_a       = {1'b0, rs1};
          dec_d.imm_en      = 1'b1;
          dec_d.lam_new     = 1'b1;
          dec_d.lam_control = {1'b0, f3, rd};
          dec_d.demux_alu   = 1'b1;
          {uses_rs1, writes_rd, is_load} = 3'b111;
        end
        OPC_STORE: begin
          imm32             = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
          dec_d.sel_a       = {1'b0, rs1};
          dec_d.sel_b       = rs2;
          dec_d.imm_en      = 1'b1;
          dec_d.lam_new     = 1'b1;
          dec_d.lam_control = {1'b1, f3, rs2};
          dec_d.demux_alu   = 1'b1;
          {uses_rs1, uses_rs2} = 2'b11;
        end
        OPC_BRANCH: begin
          if (f3 == 3'b010 || f3 == 3'b011) begin
            dec_d.illegal = 1'b1;
          end else begin
            imm32          = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            dec_d.sel_a    = {1'b0, rs1};
            dec_d.sel_b    = rs2;
            dec_d.new_jmp  = 1'b1;
            dec_d.jmp_type = f3;
            // Compare op for the ALU: SUB for eq/ne, SLT for signed, SLTU for unsigned.
            unique case (f3[2:1])
              2'b00:   dec_d.alu_ctrl = 10'b0100000000;
              2'b10:   dec_d.alu_ctrl = 10'b0000000010;
              default: dec_d.alu_ctrl = 10'b0000000011;
            endcase
            {uses_rs1, uses_rs2} = 2'b11;
          end
        end
        OPC_JAL: begin
          imm32          = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
          dec_d.sel_out  = {1'b0, rd};
          dec_d.new_jmp  = 1'b1;
          dec_d.jmp_type = 3'b010;
          writes_rd      = 1'b1;
        end
        OPC_JALR: begin
          if (f3 != 3'b000) begin
            dec_d.illegal = 1'b1;
          end else begin
            imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_d.sel_a    = {1'b0, rs1};
            dec_d.sel_out  = {1'b0, rd};
            dec_d.new_jmp  = 1'b1;
            dec_d.jmp_type = 3'b011;
            {uses_rs1, writes_rd} = 2'b11;
          end
        end
        default: dec_d.illegal = 1'b1;
      endcase
    end
    if (dec_d.illegal) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
      imm32         = '0;
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;
      writes_rd     = 1'b0;
      is_load       = 1'b0;
    end
    dec_d.imm = XLEN'($signed(imm32));
  end

  // Hazard looks only at the registered scoreboard: a same-cycle writeback
  // does not bypass, so the stall releases one cycle after wb_valid.
  assign hazard   = EN_SCOREBOARD &&
                    ((uses_rs1 && sb_q[rs1]) || (uses_rs2 && sb_q[rs2]) || (writes_rd && sb_q[rd]));
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !rst;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    sb_d = sb_q;
    if (wb_valid) sb_d[wb_rd] = 1'b0;
    // A flushed load never reaches execute, so it must not claim its rd.
    if (in_fire && !flush && is_load && rd != 5'd0) sb_d[rd] = 1'b1;
    sb_d[0] = 1'b0;
    if (!EN_SCOREBOARD) sb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      pc_q        <= '0;
      sb_q        <= '0;
    end else begin
      sb_q <= sb_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_valid_q <= 1'b1;
        dec_q       <= dec_d;
        pc_q        <= in_pc;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign alu_ctrl    = dec_q.alu_ctrl;
  assign imm         = dec_q.imm;
  assign sel_a       = dec_q.sel_a;
  assign sel_b       = dec_q.sel_b;
  assign sel_out     = dec_q.sel_out;
  assign imm_en      = dec_q.imm_en;
  assign jmp_type    = dec_q.jmp_type;
  assign new_jmp     = dec_q.new_jmp;
  assign lam_control = dec_q.lam_control;
  assign lam_new     = dec_q.lam_new;
  assign demux_alu   = dec_q.demux_alu;
  assign illegal     = dec_q.illegal;

endmodule
